ecc_op_sequencer: RTL and testbench



---
 rtl/ecc_seq_pkg.sv | 31 +++
 rtl/ecc_regfile.sv | 31 +++
 rtl/ecc_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ecc_op_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_seq_pkg.sv
// rtl/ecc_seq_pkg.sv - shared types for the ECC field-operation sequencer
package ecc_seq_pkg;

   localparam int REG_AW = 3;
   localparam int INS_W  = 3 + 3 * REG_AW;

   // Values match the core's ALU_* select codes.
   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_MULT = 3'b011,
      OP_INV  = 3'b100
   } op_e;

   typedef struct packed {
      logic [2:0]        op;
      logic [REG_AW-1:0] dst;
      logic [REG_AW-1:0] src_a;
      logic [REG_AW-1:0] src_b;
   } ins_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_e;

endpackage

// File: rtl/ecc_regfile.sv
// rtl/ecc_regfile.sv - working register file, one write port and three combinational reads
module ecc_regfile
   import ecc_seq_pkg::*;
#(
   parameter int NREG = 8,
   parameter int W    = 256,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   output logic [W-1:0]  o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [W-1:0]  o_rdata_b,
   input  logic [AW-1:0] i_raddr_h,
   output logic [W-1:0]  o_rdata_h
);

   logic [W-1:0] mem [NREG];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata_a = mem[i_raddr_a];
   assign o_rdata_b = mem[i_raddr_b];
   assign o_rdata_h = mem[i_raddr_h];

endmodule

// File: rtl/ecc_op_sequencer.sv
// rtl/ecc_op_sequencer.sv - runs a host-loaded list of field operations through the ECC ALU core
module ecc_op_sequencer
   import ecc_seq_pkg::*;
#(
   parameter int NREG       = 8,
   parameter int PROG_DEPTH = 16,
   parameter int TIMEOUT    = 4096,
   parameter int AW         = $clog2(NREG),
   parameter int PW         = $clog2(PROG_DEPTH),
   parameter int IW         = 3 + 3 * AW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [PW:0]   i_prog_len,
   input  logic [255:0]  i_prime,
   input  logic          i_reg_we,
   input  logic [AW-1:0] i_reg_waddr,
   input  logic [255:0]  i_reg_wdata,
   input  logic [AW-1:0] i_reg_raddr,
   output logic [255:0]  o_reg_rdata,
   input  logic          i_ins_we,
   input  logic [PW-1:0] i_ins_addr,
   input  logic [IW-1:0] i_ins_data,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_error,
   output logic [PW-1:0] o_pc,
   output logic          o_core_start,
   output logic [2:0]    o_core_sel,
   output logic [255:0]  o_core_a,
   output logic [255:0]  o_core_b,
   output logic [255:0]  o_core_prime,
   input  logic [255:0]  i_core_result,
   input  logic          i_core_done
);

   localparam int LW = PW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_e         state, state_n;
   logic [PW-1:0]  pc, pc_n;
   logic [LW-1:0]  prog_len, len_n, pc_inc;
   logic           err_n, wb_en;
   logic [2:0]     sel_n;
   logic [255:0]   a_n, b_n, prime_n;
   logic [CW-1:0]  tmo_cnt, cnt_n;

   logic [IW-1:0]  prog [PROG_DEPTH];
   logic [IW-1:0]  cur_ins;
   logic [2:0]     cur_op;
   logic [AW-1:0]  cur_dst, cur_src_a, cur_src_b;
   logic [255:0]   rd_a, rd_b;

   always_ff @(posedge i_clk) begin
      if (i_ins_we && !o_busy) prog[i_ins_addr] <= i_ins_data;
   end

   assign cur_ins   = prog[pc];
   assign cur_op    = cur_ins[IW-1 -: 3];
   assign cur_dst   = cur_ins[3*AW-1 -: AW];
   assign cur_src_a = cur_ins[2*AW-1 -: AW];
   assign cur_src_b = cur_ins[AW-1:0];
   assign pc_inc    = {1'b0, pc} + LW'(1);

   // Write-back only happens while busy, so it never collides with an accepted host write.
   ecc_regfile #(.NREG(NREG), .W(256), .AW(AW)) u_regfile (
      .i_clk     (i_clk),
      .i_we      (wb_en | (i_reg_we & ~o_busy)),
      .i_waddr   (wb_en ? cur_dst : i_reg_waddr),
      .i_wdata   (wb_en ? i_core_result : i_reg_wdata),
      .i_raddr_a (cur_src_a),
      .o_rdata_a (rd_a),
      .i_raddr_b (cur_src_b),
      .o_rdata_b (rd_b),
      .i_raddr_h (i_reg_raddr),
      .o_rdata_h (o_reg_rdata)
   );

   always_comb begin
      state_n = state;
      pc_n    = pc;
      len_n   = prog_len;
      err_n   = o_error;
      sel_n   = o_core_sel;
      a_n     = o_core_a;
      b_n     = o_core_b;
      prime_n = o_core_prime;
      cnt_n   = tmo_cnt;
      wb_en   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               err_n   = 1'b0;
               prime_n = i_prime;
               pc_n    = '0;
               len_n   = (i_prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : i_prog_len;
               state_n = (i_prog_len == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH: begin
            case (cur_op)
               OP_NOP: begin
                  pc_n    = pc_inc[PW-1:0];
                  state_n = (pc_inc < prog_len) ? S_FETCH : S_FINISH;
               end
               OP_ADD, OP_SUB, OP_MULT, OP_INV: begin
                  sel_n   = cur_op;
                  a_n     = rd_a;
                  b_n     = rd_b;
                  state_n = S_ISSUE;
               end
               default: begin
                  err_n   = 1'b1;
                  state_n = S_FINISH;
               end
            endcase
         end
         S_ISSUE: begin
            cnt_n   = '0;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            // sel/a/b stay put here: the core's result mux follows alu_sel while done is high.
            if (i_core_done) begin
               wb_en   = 1'b1;
               pc_n    = pc_inc[PW-1:0];
               state_n = (pc_inc < prog_len) ? S_FETCH : S_FINISH;
            end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = S_FINISH;
            end else begin
               cnt_n = tmo_cnt + CW'(1);
            end
         end
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         pc           <= '0;
         prog_len     <= '0;
         o_error      <= 1'b0;
         o_core_sel   <= 3'b000;
         o_core_a     <= '0;
         o_core_b     <= '0;
         o_core_prime <= '0;
         tmo_cnt      <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         prog_len     <= len_n;
         o_error      <= err_n;
         o_core_sel   <= sel_n;
         o_core_a     <= a_n;
         o_core_b     <= b_n;
         o_core_prime <= prime_n;
         tmo_cnt      <= cnt_n;
      end
   end

   assign o_busy       = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
   assign o_done       = (state == S_FINISH);
   assign o_core_start = (state == S_ISSUE);
   assign o_pc         = pc;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// tb/tb_ecc_op_sequencer.sv - directed bench with a 5-cycle behavioural core, p = 97
module tb_ecc_op_sequencer;
   import ecc_seq_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [4:0]   prog_len;
   logic [255:0] prime;
   logic         reg_we;
   logic [2:0]   reg_waddr;
   logic [255:0] reg_wdata;
   logic [2:0]   reg_raddr;
   logic [255:0] reg_rdata;
   logic         ins_we;
   logic [3:0]   ins_addr;
   logic [11:0]  ins_data;
   logic         busy, done, error;
   logic [3:0]   pc;
   logic         core_start;
   logic [2:0]   core_sel;
   logic [255:0] core_a, core_b, core_prime;
   logic [255:0] core_result = '0;
   logic         core_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int cycles;
   int s0;
   int npc;
   logic [3:0] pc_log [64];
   bit core_hang = 1'b0;

   always #5 clk = ~clk;

   ecc_op_sequencer #(.NREG(8), .PROG_DEPTH(16), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_prog_len(prog_len), .i_prime(prime),
      .i_reg_we(reg_we), .i_reg_waddr(reg_waddr), .i_reg_wdata(reg_wdata),
      .i_reg_raddr(reg_raddr), .o_reg_rdata(reg_rdata),
      .i_ins_we(ins_we), .i_ins_addr(ins_addr), .i_ins_data(ins_data),
      .o_busy(busy), .o_done(done), .o_error(error), .o_pc(pc),
      .o_core_start(core_start), .o_core_sel(core_sel), .o_core_a(core_a), .o_core_b(core_b),
      .o_core_prime(core_prime), .i_core_result(core_result), .i_core_done(core_done)
   );

   function automatic logic [255:0] model_alu(input logic [2:0] sel, input logic [255:0] a,
                                              input logic [255:0] b, input logic [255:0] p);
      longint av = longint'(a[31:0]);
      longint bv = longint'(b[31:0]);
      longint pv = longint'(p[31:0]);
      longint r  = 0;
      case (sel)
         3'b001: r = (av + bv) % pv;
         3'b010: r = (av + pv - bv) % pv;
         3'b011: r = (av * bv) % pv;
         3'b100: for (longint x = 1; x < pv; x++) if ((av * x) % pv == 1) r = (bv * x) % pv;
         default: r = 0;
      endcase
      return 256'(r);
   endfunction

   logic         m_active = 1'b0;
   int           m_cnt = 0;
   logic [255:0] m_res = '0;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (core_start) starts <= starts + 1;
      if (!rst_n) begin
         m_active <= 1'b0;
      end else if (core_start) begin
         m_active <= 1'b1;
         m_cnt    <= 1;
         m_res    <= model_alu(core_sel, core_a, core_b, core_prime);
      end else if (m_active) begin
         if (m_cnt == 4 && !core_hang) begin
            core_done   <= 1'b1;
            core_result <= m_res;
            m_active    <= 1'b0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [255:0] d);
      @(negedge clk); reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
      @(negedge clk); reg_we = 1'b0;
   endtask

   task automatic wi(input logic [3:0] slot, input logic [2:0] op, input logic [2:0] d,
                     input logic [2:0] a, input logic [2:0] b);
      ins_t w;
      w.op = op; w.dst = d; w.src_a = a; w.src_b = b;
      @(negedge clk); ins_we = 1'b1; ins_addr = slot; ins_data = w;
      @(negedge clk); ins_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [255:0] d);
      reg_raddr = a;
      #1 d = reg_rdata;
   endtask

   task automatic run(input logic [4:0] len, input bit inject, output int cyc);
      npc = 0;
      @(negedge clk); prog_len = len; prime = 256'd97; start = 1'b1;
      @(negedge clk); start = 1'b0; cyc = 1;
      while (!done && cyc < 100) begin
         if (busy && npc < 64) begin pc_log[npc] = pc; npc++; end
         if (inject && cyc == 3) begin
            start = 1'b1; prog_len = 5'd1; reg_we = 1'b1; reg_waddr = 3'd7; reg_wdata = 256'd123;
         end
         @(negedge clk); start = 1'b0; reg_we = 1'b0; cyc++;
      end
      check("done_seen", {255'd0, done}, 256'd1);
   endtask

   logic [255:0] v;

   initial begin
      rst_n = 1'b0; start = 1'b0; prog_len = '0; prime = '0; reg_we = 1'b0; reg_waddr = '0;
      reg_wdata = '0; reg_raddr = '0; ins_we = 1'b0; ins_addr = '0; ins_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {255'd0, busy}, 256'd0);
      check("rst_done", {255'd0, done}, 256'd0);
      check("rst_error", {255'd0, error}, 256'd0);
      check("rst_start", {255'd0, core_start}, 256'd0);
      check("rst_sel", {253'd0, core_sel}, 256'd0);
      check("rst_a", core_a, 256'd0);
      check("rst_b", core_b, 256'd0);
      check("rst_prime", core_prime, 256'd0);
      check("rst_pc", {252'd0, pc}, 256'd0);
      @(negedge clk); rst_n = 1'b1;

      // ADD r2 = 50 + 60 mod 97
      wr(0, 50); wr(1, 60); wi(0, OP_ADD, 2, 0, 1);
      s0 = starts;
      run(1, 0, cycles);
      check("t1_cycles", 256'(cycles), 256'd8);
      check("t1_prime", core_prime, 256'd97);
      @(negedge clk);
      check("t1_done_pulse", {255'd0, done}, 256'd0);
      check("t1_starts", 256'(starts - s0), 256'd1);
      rd(2, v); check("t1_r2", v, 256'd13);

      // SUB then MULT consuming the fresh result
      wr(0, 10); wr(1, 20); wi(0, OP_SUB, 3, 0, 1); wi(1, OP_MULT, 4, 3, 1);
      s0 = starts;
      run(2, 0, cycles);
      @(negedge clk);
      check("t2_starts", 256'(starts - s0), 256'd2);
      rd(3, v); check("t2_r3", v, 256'd87);
      rd(4, v); check("t2_r4", v, 256'd91);

      // NOP / ADD / NOP
      wr(0, 50); wi(0, OP_NOP, 0, 0, 0); wi(1, OP_ADD, 5, 0, 0); wi(2, OP_NOP, 0, 0, 0);
      s0 = starts;
      run(3, 0, cycles);
      check("t3_pc0", {252'd0, pc_log[0]}, 256'd0);
      check("t3_pc1", {252'd0, pc_log[1]}, 256'd1);
      check("t3_pc2", {252'd0, pc_log[2]}, 256'd1);
      check("t3_pclast", {252'd0, pc_log[npc-1]}, 256'd2);
      @(negedge clk);
      check("t3_starts", 256'(starts - s0), 256'd1);
      rd(5, v); check("t3_r5", v, 256'd3);

      // illegal opcode 110
      wi(0, 3'b110, 1, 1, 1);
      s0 = starts;
      run(1, 0, cycles);
      check("t4_cycles", 256'(cycles), 256'd2);
      check("t4_error", {255'd0, error}, 256'd1);
      @(negedge clk);
      check("t4_starts", 256'(starts - s0), 256'd0);
      check("t4_error_sticky", {255'd0, error}, 256'd1);

      // INV: 3 * 5^-1 mod 97 = 20; also clears the earlier error
      wr(0, 5); wr(1, 3); wi(0, OP_INV, 6, 0, 1);
      run(1, 0, cycles);
      check("t5_error_clr", {255'd0, error}, 256'd0);
      @(negedge clk);
      rd(6, v); check("t5_r6", v, 256'd20);

      // zero-length program
      s0 = starts;
      run(0, 0, cycles);
      check("t6_cycles", 256'(cycles), 256'd1);
      @(negedge clk);
      check("t6_starts", 256'(starts - s0), 256'd0);

      // start and register write while busy are dropped
      wr(0, 50); wr(1, 60); wr(7, 5); wi(0, OP_ADD, 2, 0, 1);
      s0 = starts;
      run(1, 1, cycles);
      check("t7_cycles", 256'(cycles), 256'd8);
      repeat (3) @(negedge clk);
      check("t7_idle", {255'd0, busy}, 256'd0);
      check("t7_starts", 256'(starts - s0), 256'd1);
      rd(7, v); check("t7_r7", v, 256'd5);
      rd(2, v); check("t7_r2", v, 256'd13);

      // core never answers: timeout after 16 WAIT cycles, dst untouched
      wr(6, 77); wi(0, OP_ADD, 6, 0, 1);
      core_hang = 1'b1;
      run(1, 0, cycles);
      check("t8_cycles", 256'(cycles), 256'd19);
      check("t8_error", {255'd0, error}, 256'd1);
      @(negedge clk);
      rd(6, v); check("t8_r6", v, 256'd77);
      rst_n = 1'b0; core_hang = 1'b0;
      @(negedge clk);
      check("t8_rst_error", {255'd0, error}, 256'd0);
      check("t8_rst_busy", {255'd0, busy}, 256'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
